amo_bank_arbiter: RTL and testbench
===================================

AMO_BANK_ARBITER -- requirements
Module: amo_bank_arbiter

Interface
REQ-001 SHALL have parameter NumIn, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter AddrMemWidth, default 32, bank word address width.
REQ-003 SHALL have parameter DataWidth, default 32, data width (32 or 64 only).
REQ-004 SHALL have port clk_i, input, 1, single clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports req_i / gnt_o, input / output, NumIn each, per-requester request and grant.
REQ-007 SHALL have ports add_i, amo_i, wen_i, wdata_i, be_i, input, NumIn x (AddrMemWidth, 4, 1, DataWidth, DataWidth/8), per-requester payload.
REQ-008 SHALL have ports rvalid_o (output, NumIn) and rdata_o (output, DataWidth), per-requester response valid and shared response data.
REQ-009 SHALL have ports out_req_o, out_add_o, out_amo_o, out_wen_o, out_wdata_o, out_be_o, output, payload widths as above, bank-side request toward the AMO shim.
REQ-010 SHALL have ports out_gnt_i (input, 1) and out_rdata_i (input, DataWidth), bank-side grant and read data.

Function
REQ-011 SHALL hold a 2-state FSM: Ready and AmoLock.
REQ-012 SHALL, in Ready, select the lowest index i >= rr_q with req_i[i]=1, wrapping past NumIn-1 to 0.
REQ-013 SHALL drive out_req_o=1 and the selected payload on out_* combinationally whenever any req_i is high in Ready.
REQ-014 SHALL assert gnt_o[i] only for the selected i, only when out_gnt_i=1, and never for more than one index per cycle.
REQ-015 SHALL, on a grant to index i, set rr_q to (i+1) mod NumIn at the next edge.
REQ-016 SHALL hold rr_q when no grant occurs, including req high with out_gnt_i low.
REQ-017 SHALL, on a grant with amo_i != 0, move to AmoLock at the next edge.
REQ-018 SHALL, in AmoLock, drive out_req_o=0 and all gnt_o=0 regardless of req_i, and return to Ready after exactly one cycle.
REQ-019 SHALL register the granted index and a valid flag, and assert rvalid_o[idx] exactly one cycle after each grant (loads, stores and AMOs alike).
REQ-020 SHALL drive rdata_o = out_rdata_i combinationally; rdata_o is meaningful only while some rvalid_o is high.
REQ-021 SHALL drive the AMO response during the AmoLock cycle, returning the pre-operation memory value.
REQ-022 SHALL have a back-to-back non-AMO throughput of one grant per cycle, and at most one grant per two cycles for AMOs.
REQ-023 SHALL drive zero on out_add_o, out_amo_o, out_wen_o, out_wdata_o and out_be_o when out_req_o=0.
REQ-024 SHALL let a requester dropping req_i without a grant leave no state behind; the pointer is unaffected.
REQ-025 SHALL treat NumIn=1 as always selecting index 0, with rr_q fixed at 0.

Reset
REQ-026 SHALL, while rst_ni=0, asynchronously set the FSM to Ready, rr_q=0 and the response valid flag=0, so that rvalid_o=0 and out_req_o follows req_i.
REQ-027 SHALL, if reset is asserted in AmoLock or with a response pending, drop the pending rvalid and not emit it after release.
REQ-028 SHALL, on the first cycle after release, select index 0 first.

Verification
REQ-029 SHALL be verified by this scenario: NumIn=4, out_gnt_i=1, req_i=4'b1111 for 4 cycles with loads only -> grants to 0, 1, 2, 3 in consecutive cycles, and rvalid_o one cycle after each.
REQ-030 SHALL be verified by this scenario: req_i[1] AMOAdd (amo_i=2), memory word holds 5, wdata 3, req_i[2] load pending -> gnt_o[1] in cycle N, no grant in N+1 with rvalid_o[1]=1 and rdata_o=5, gnt_o[2] in N+2.
REQ-031 SHALL be verified by this scenario: req_i=4'b0101, out_gnt_i=0 for 3 cycles then 1 -> no gnt_o and rr_q held for 3 cycles, then gnt_o[0] followed by gnt_o[2].
REQ-032 SHALL be verified by this scenario: rr_q=3, req_i=4'b1001 -> gnt_o[3] first, then wrap to gnt_o[0].
REQ-033 SHALL be verified by this scenario: rst_ni pulsed low during AmoLock -> rvalid_o stays 0, FSM is Ready, and the next grant goes to the lowest requesting index.
REQ-034 SHALL be verified by this assertion, checked every cycle: $onehot0(gnt_o), and out_req_o=0 whenever the FSM is in AmoLock.

Source files
------------

// File: rtl/amo_bank_arbiter.sv
// Round-robin arbiter that funnels NumIn requesters into one memory bank behind an AMO shim.
// After an atomic is granted the bank is held off for one cycle while the shim does its write-back.
module amo_bank_arbiter #(
    parameter int unsigned NumIn        = 4,
    parameter int unsigned AddrMemWidth = 32,
    parameter int unsigned DataWidth    = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumIn-1:0]                       req_i,
    output logic [NumIn-1:0]                       gnt_o,
    input  logic [NumIn-1:0][AddrMemWidth-1:0]     add_i,
    input  logic [NumIn-1:0][3:0]                  amo_i,
    input  logic [NumIn-1:0]                       wen_i,
    input  logic [NumIn-1:0][DataWidth-1:0]        wdata_i,
    input  logic [NumIn-1:0][DataWidth/8-1:0]      be_i,
    output logic [NumIn-1:0]                       rvalid_o,
    output logic [DataWidth-1:0]                   rdata_o,
    output logic                                   out_req_o,
    output logic [AddrMemWidth-1:0]                out_add_o,
    output logic [3:0]                             out_amo_o,
    output logic                                   out_wen_o,
    output logic [DataWidth-1:0]                   out_wdata_o,
    output logic [DataWidth/8-1:0]                 out_be_o,
    input  logic                                   out_gnt_i,
    input  logic [DataWidth-1:0]                   out_rdata_i
);

    localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;

    typedef enum logic [0:0] {
        Ready   = 1'b0,
        AmoLock = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] ridx_q, ridx_d;
    logic            rvalid_q, rvalid_d;

    logic [IdxW:0]   cand_s;
    logic [IdxW:0]   next_rr_s;
    logic [IdxW-1:0] sel_idx_s;
    logic            sel_valid_s;
    logic            grant_s;

    // Pick the first requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_idx_s   = '0;
        cand_s      = '0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            cand_s = {1'b0, rr_q} + (IdxW+1)'(k);
            if (cand_s >= (IdxW+1)'(NumIn)) begin
                cand_s = cand_s - (IdxW+1)'(NumIn);
            end else begin
                cand_s = cand_s;
            end
            if (!sel_valid_s && req_i[cand_s[IdxW-1:0]]) begin
                sel_valid_s = 1'b1;
                sel_idx_s   = cand_s[IdxW-1:0];
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
    end

    // Bank-side request and grant; payload is forced to zero while idle so the bus stays quiet.
    always_comb begin
        out_req_o   = (state_q == Ready) && sel_valid_s;
        grant_s     = out_req_o && out_gnt_i;
        gnt_o       = '0;
        out_add_o   = '0;
        out_amo_o   = 4'd0;
        out_wen_o   = 1'b0;
        out_wdata_o = '0;
        out_be_o    = '0;
        if (out_req_o) begin
            out_add_o   = add_i[sel_idx_s];
            out_amo_o   = amo_i[sel_idx_s];
            out_wen_o   = wen_i[sel_idx_s];
            out_wdata_o = wdata_i[sel_idx_s];
            out_be_o    = be_i[sel_idx_s];
        end else begin
            out_add_o   = '0;
        end
        if (grant_s) begin
            gnt_o[sel_idx_s] = 1'b1;
        end else begin
            gnt_o = '0;
        end
    end

    // Next-state for the pointer, the lock FSM and the one-cycle-later response tag.
    always_comb begin
        next_rr_s = {1'b0, sel_idx_s} + (IdxW+1)'(1);
        rr_d      = rr_q;
        ridx_d    = ridx_q;
        rvalid_d  = grant_s;
        state_d   = state_q;
        if (grant_s) begin
            rr_d   = (next_rr_s >= (IdxW+1)'(NumIn)) ? '0 : next_rr_s[IdxW-1:0];
            ridx_d = sel_idx_s;
        end else begin
            rr_d   = rr_q;
        end
        case (state_q)
            Ready:   state_d = (grant_s && (out_amo_o != 4'd0)) ? AmoLock : Ready;
            AmoLock: state_d = Ready;
            default: state_d = Ready;
        endcase
    end

    // State registers; reset also discards any response still in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= Ready;
            rr_q     <= '0;
            ridx_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            ridx_q   <= ridx_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Response: the AMO's old value arrives from the shim during the lock cycle.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = out_rdata_i;
        if (rvalid_q) begin
            rvalid_o[ridx_q] = 1'b1;
        end else begin
            rvalid_o = '0;
        end
    end

    amo_bank_arbiter_chk #(
        .NumIn (NumIn)
    ) u_chk (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .gnt_i     (gnt_o),
        .out_req_i (out_req_o),
        .lock_i    (state_q == AmoLock)
    );

endmodule

// Protocol invariants: at most one grant per cycle and no bank request while locked.
module amo_bank_arbiter_chk #(
    parameter int unsigned NumIn = 4
) (
    input logic             clk_i,
    input logic             rst_ni,
    input logic [NumIn-1:0] gnt_i,
    input logic             out_req_i,
    input logic             lock_i
);

    a_onehot_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_i));
    a_lock_quiet: assert property (@(posedge clk_i) disable iff (!rst_ni) !(lock_i && out_req_i));

endmodule

// File: tb/tb_amo_bank_arbiter.sv
// Directed bench for amo_bank_arbiter: a cycle-per-row vector table plus a reset-in-lock sequence.
module tb_amo_bank_arbiter;

    logic                  clk;
    logic                  rst_n;
    logic [3:0]            req;
    logic [3:0]            gnt;
    logic [3:0][31:0]      add;
    logic [3:0][3:0]       amo;
    logic [3:0]            wen;
    logic [3:0][31:0]      wdata;
    logic [3:0][3:0]       be;
    logic [3:0]            rvalid;
    logic [31:0]           rdata;
    logic                  out_req;
    logic [31:0]           out_add;
    logic [3:0]            out_amo;
    logic                  out_wen;
    logic [31:0]           out_wdata;
    logic [3:0]            out_be;
    logic                  out_gnt;
    logic [31:0]           out_rdata;

    int n_run  = 0;
    int n_fail = 0;

    amo_bank_arbiter #(
        .NumIn        (4),
        .AddrMemWidth (32),
        .DataWidth    (32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .gnt_o       (gnt),
        .add_i       (add),
        .amo_i       (amo),
        .wen_i       (wen),
        .wdata_i     (wdata),
        .be_i        (be),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .out_req_o   (out_req),
        .out_add_o   (out_add),
        .out_amo_o   (out_amo),
        .out_wen_o   (out_wen),
        .out_wdata_o (out_wdata),
        .out_be_o    (out_be),
        .out_gnt_i   (out_gnt),
        .out_rdata_i (out_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [3:0]  amo_m;
        logic        og;
        logic [31:0] rd;
        logic [3:0]  e_gnt;
        logic        e_oreq;
        logic [3:0]  e_rv;
        logic [31:0] e_add;
        logic [3:0]  e_amo;
    } vec_t;

    localparam int NVec = 27;
    vec_t tbl [NVec];

    function automatic vec_t v(input logic r, input logic [3:0] rq, input logic [3:0] am,
                               input logic og, input logic [31:0] rd, input logic [3:0] eg,
                               input logic eo, input logic [3:0] erv, input logic [31:0] ea,
                               input logic [3:0] eam);
        vec_t t;
        t.rst_n = r;  t.req = rq;  t.amo_m = am;  t.og = og;   t.rd = rd;
        t.e_gnt = eg; t.e_oreq = eo; t.e_rv = erv; t.e_add = ea; t.e_amo = eam;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rq, input logic [3:0] am, input logic og,
                         input logic [31:0] rd);
        req       = rq;
        out_gnt   = og;
        out_rdata = rd;
        for (int i = 0; i < 4; i++) begin
            amo[i] = am[i] ? 4'd2 : 4'd0;
        end
    endtask

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_1001;
    localparam logic [31:0] A2 = 32'h0000_1002;
    localparam logic [31:0] A3 = 32'h0000_1003;
    localparam logic [31:0] Z  = 32'h0000_0000;
    localparam logic [31:0] RD = 32'hCAFE_0011;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            add[i]   = 32'h0000_1000 + 32'(i);
            wen[i]   = 1'b0;
            wdata[i] = 32'd3;
            be[i]    = 4'hF;
        end
        drive(4'b0000, 4'b0000, 1'b0, 32'd0);

        //             rst   req      amo      og    rd      gnt      oreq  rv       add amo
        tbl[0]  = v(1'b0, 4'b0000, 4'b0000, 1'b0, RD,    4'b0000, 1'b0, 4'b0000, Z,  4'd0);
        tbl[1]  = v(1'b0, 4'b0110, 4'b0000, 1'b0, RD,    4'b0000, 1'b1, 4'b0000, A1, 4'd0);
        tbl[2]  = v(1'b1, 4'b1111, 4'b0000, 1'b1, RD,    4'b0001, 1'b1, 4'b0000, A0, 4'd0);
        tbl[3]  = v(1'b1, 4'b1111, 4'b0000, 1'b1, RD,    4'b0010, 1'b1, 4'b0001, A1, 4'd0);
        tbl[4]  = v(1'b1, 4'b1111, 4'b0000, 1'b1, RD,    4'b0100, 1'b1, 4'b0010, A2, 4'd0);
        tbl[5]  = v(1'b1, 4'b1111, 4'b0000, 1'b1, RD,    4'b1000, 1'b1, 4'b0100, A3, 4'd0);
        tbl[6]  = v(1'b1, 4'b0000, 4'b0000, 1'b1, RD,    4'b0000, 1'b0, 4'b1000, Z,  4'd0);
        tbl[7]  = v(1'b1, 4'b0101, 4'b0000, 1'b0, RD,    4'b0000, 1'b1, 4'b0000, A0, 4'd0);
        tbl[8]  = v(1'b1, 4'b0101, 4'b0000, 1'b0, RD,    4'b0000, 1'b1, 4'b0000, A0, 4'd0);
        tbl[9]  = v(1'b1, 4'b0101, 4'b0000, 1'b0, RD,    4'b0000, 1'b1, 4'b0000, A0, 4'd0);
        tbl[10] = v(1'b1, 4'b0101, 4'b0000, 1'b1, RD,    4'b0001, 1'b1, 4'b0000, A0, 4'd0);
        tbl[11] = v(1'b1, 4'b0101, 4'b0000, 1'b1, RD,    4'b0100, 1'b1, 4'b0001, A2, 4'd0);
        tbl[12] = v(1'b1, 4'b0000, 4'b0000, 1'b1, RD,    4'b0000, 1'b0, 4'b0100, Z,  4'd0);
        tbl[13] = v(1'b1, 4'b1001, 4'b0000, 1'b1, RD,    4'b1000, 1'b1, 4'b0000, A3, 4'd0);
        tbl[14] = v(1'b1, 4'b1001, 4'b0000, 1'b1, RD,    4'b0001, 1'b1, 4'b1000, A0, 4'd0);
        tbl[15] = v(1'b1, 4'b0000, 4'b0000, 1'b1, RD,    4'b0000, 1'b0, 4'b0001, Z,  4'd0);
        tbl[16] = v(1'b1, 4'b0110, 4'b0010, 1'b1, RD,    4'b0010, 1'b1, 4'b0000, A1, 4'd2);
        tbl[17] = v(1'b1, 4'b0100, 4'b0000, 1'b1, 32'd5, 4'b0000, 1'b0, 4'b0010, Z,  4'd0);
        tbl[18] = v(1'b1, 4'b0100, 4'b0000, 1'b1, RD,    4'b0100, 1'b1, 4'b0000, A2, 4'd0);
        tbl[19] = v(1'b1, 4'b0000, 4'b0000, 1'b1, RD,    4'b0000, 1'b0, 4'b0100, Z,  4'd0);
        tbl[20] = v(1'b1, 4'b0001, 4'b0000, 1'b0, RD,    4'b0000, 1'b1, 4'b0000, A0, 4'd0);
        tbl[21] = v(1'b1, 4'b1000, 4'b0000, 1'b1, RD,    4'b1000, 1'b1, 4'b0000, A3, 4'd0);
        tbl[22] = v(1'b1, 4'b0011, 4'b0011, 1'b1, RD,    4'b0001, 1'b1, 4'b1000, A0, 4'd2);
        tbl[23] = v(1'b1, 4'b0010, 4'b0010, 1'b1, RD,    4'b0000, 1'b0, 4'b0001, Z,  4'd0);
        tbl[24] = v(1'b1, 4'b0010, 4'b0010, 1'b1, RD,    4'b0010, 1'b1, 4'b0000, A1, 4'd2);
        tbl[25] = v(1'b1, 4'b0100, 4'b0000, 1'b1, RD,    4'b0000, 1'b0, 4'b0010, Z,  4'd0);
        tbl[26] = v(1'b1, 4'b0100, 4'b0000, 1'b1, RD,    4'b0100, 1'b1, 4'b0000, A2, 4'd0);

        for (int i = 0; i < NVec; i++) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n;
            drive(tbl[i].req, tbl[i].amo_m, tbl[i].og, tbl[i].rd);
            #1;
            chk($sformatf("v%0d gnt", i),     32'(gnt),     32'(tbl[i].e_gnt));
            chk($sformatf("v%0d out_req", i), 32'(out_req), 32'(tbl[i].e_oreq));
            chk($sformatf("v%0d rvalid", i),  32'(rvalid),  32'(tbl[i].e_rv));
            chk($sformatf("v%0d out_add", i), out_add,      tbl[i].e_add);
            chk($sformatf("v%0d out_amo", i), 32'(out_amo), 32'(tbl[i].e_amo));
            if (tbl[i].e_rv != 4'b0000) begin
                chk($sformatf("v%0d rdata", i), rdata, tbl[i].rd);
            end
        end

        // Reset pulse while the arbiter is locked after an AMO grant.
        @(negedge clk);
        drive(4'b0100, 4'b0100, 1'b1, RD);
        #1;
        chk("lock gnt", 32'(gnt), 32'(4'b0100));
        @(posedge clk);
        #1;
        chk("lock quiet", 32'(out_req), 32'(1'b0));
        #1;
        rst_n = 1'b0;
        #2;
        chk("rst rvalid", 32'(rvalid), 32'(4'b0000));
        rst_n = 1'b1;
        @(negedge clk);
        drive(4'b1010, 4'b0000, 1'b1, RD);
        #1;
        chk("post rst rvalid", 32'(rvalid),  32'(4'b0000));
        chk("post rst out_req", 32'(out_req), 32'(1'b1));
        chk("post rst gnt",    32'(gnt),     32'(4'b0010));
        @(negedge clk);
        drive(4'b0000, 4'b0000, 1'b1, RD);
        #1;
        chk("post rst resp", 32'(rvalid), 32'(4'b0010));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
